// File: rtl/filter_frame_ctrl_pkg.sv
// Shared definitions for the mean-filter frame sequencer.
package filter_pkg;
   localparam int PIX_W     = 12;
   localparam int IMG_W_DEF = 320;
   localparam int IMG_H_DEF = 240;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/filter_frame_ctrl_counter.sv
// Up-counter with synchronous clear that stops at MAX and flags terminal count.
module frame_addr_counter #(
   parameter int W   = 17,
   parameter int MAX = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);
   logic [W-1:0] r_cnt;
   logic         w_tc;

   assign w_tc  = (r_cnt == W'(MAX));
   assign o_cnt = r_cnt;
   assign o_tc  = w_tc;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)          r_cnt <= '0;
      else if (i_clr)        r_cnt <= '0;
      else if (i_en && !w_tc) r_cnt <= r_cnt + W'(1);
   end
endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer: streams one frame from the input buffer into the 3x3 mean
// filter and writes the filter's outputs to the output buffer in order.
module filter_frame_ctrl
   import filter_pkg::*;
#(
   parameter int IMG_W     = IMG_W_DEF,
   parameter int IMG_H     = IMG_H_DEF,
   parameter int PIX_W     = filter_pkg::PIX_W,
   parameter int ADDR_W    = 17,
   parameter int OUT_CNT   = (IMG_W-2)*(IMG_H-2),
   parameter int DRAIN_MAX = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_hold,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [PIX_W-1:0]  i_rd_data,
   output logic              o_flt_wenable,
   output logic [PIX_W-1:0]  o_flt_pixel,
   input  logic              i_flt_oenable,
   input  logic [PIX_W-1:0]  i_flt_pixel_post,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [PIX_W-1:0]  o_wr_data,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_timeout
);
   localparam int PIX_N  = IMG_W*IMG_H;
   localparam int IDLE_W = $clog2(DRAIN_MAX+1);

   state_t              r_state, w_next;
   logic                w_rd_en, w_busy, w_done;
   logic                w_start_ok, w_acc, w_out_reach, w_to_hit;
   logic [ADDR_W-1:0]   w_rd_cnt, w_out_cnt;
   logic                w_rd_tc, w_out_tc;
   logic [IDLE_W-1:0]   r_idle_cnt;
   logic                r_fwen, r_wen, r_timeout;
   logic [ADDR_W-1:0]   r_waddr;
   logic [PIX_W-1:0]    r_wdata;

   assign w_start_ok  = i_start && (r_state == ST_IDLE);
   assign w_acc       = i_flt_oenable && !w_out_tc &&
                        ((r_state == ST_FEED) || (r_state == ST_DRAIN));
   // The output that lands on the last slot finishes the frame in its own cycle.
   assign w_out_reach = w_out_tc || (w_acc && (w_out_cnt == ADDR_W'(OUT_CNT-1)));
   assign w_to_hit    = (r_state == ST_DRAIN) && !i_flt_oenable &&
                        (r_idle_cnt == IDLE_W'(DRAIN_MAX-1));

   frame_addr_counter #(.W(ADDR_W), .MAX(PIX_N-1)) u_rd_cnt (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_start_ok), .i_en(w_rd_en),
      .o_cnt(w_rd_cnt), .o_tc(w_rd_tc)
   );

   frame_addr_counter #(.W(ADDR_W), .MAX(OUT_CNT)) u_out_cnt (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_start_ok), .i_en(w_acc),
      .o_cnt(w_out_cnt), .o_tc(w_out_tc)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_rd_en = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         ST_IDLE:  if (i_start) w_next = ST_FEED;
         ST_FEED: begin
            w_busy  = 1'b1;
            w_rd_en = !i_hold;
            if (w_rd_en && w_rd_tc) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_busy = 1'b1;
            if (w_out_reach || w_to_hit) w_next = ST_DONE;
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                                        r_idle_cnt <= '0;
      else if ((r_state == ST_DRAIN) && !i_flt_oenable)    r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      else                                                 r_idle_cnt <= '0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_fwen    <= 1'b0;
         r_wen     <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_fwen <= w_rd_en;
         r_wen  <= w_acc;
         if (w_acc) begin
            r_waddr <= w_out_cnt;
            r_wdata <= i_flt_pixel_post;
         end
         if (w_start_ok)                     r_timeout <= 1'b0;
         else if (w_to_hit && !w_out_reach)  r_timeout <= 1'b1;
      end
   end

   // The buffer's own read register is the 1-cycle stage, so its data already
   // lines up with the delayed strobe.
   assign o_flt_pixel   = r_fwen ? i_rd_data : '0;
   assign o_flt_wenable = r_fwen;
   assign o_rd_en       = w_rd_en;
   assign o_rd_addr     = w_rd_cnt;
   assign o_wr_en       = r_wen;
   assign o_wr_addr     = r_waddr;
   assign o_wr_data     = r_wdata;
   assign o_busy        = w_busy;
   assign o_done        = w_done;
   assign o_timeout     = r_timeout;
endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Directed bench for filter_frame_ctrl on a 4x4 frame with a small filter model.
module tb_filter_frame_ctrl;
   localparam int AW = 5;
   localparam int PW = 12;
   localparam int DMAX = 8;

   logic          clk = 1'b0;
   logic          rst_n, start, hold;
   logic          rd_en, fwen, oen, wen, busy, done, timeout;
   logic [AW-1:0] rd_addr, waddr;
   logic [PW-1:0] rd_data, fpix, post, wdata;

   logic          m_clr, m_oen, f_oen;
   logic [PW-1:0] m_post, f_post;
   int            m_in, m_emit, m_lim;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   filter_frame_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(PW), .ADDR_W(AW),
                       .OUT_CNT(4), .DRAIN_MAX(DMAX)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_hold(hold),
      .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
      .o_flt_wenable(fwen), .o_flt_pixel(fpix),
      .i_flt_oenable(oen), .i_flt_pixel_post(post),
      .o_wr_en(wen), .o_wr_addr(waddr), .o_wr_data(wdata),
      .o_busy(busy), .o_done(done), .o_timeout(timeout)
   );

   function automatic logic [PW-1:0] pat(input int a);
      return 12'h5A0 + PW'(a);
   endfunction

   always @(posedge clk) if (rd_en) rd_data <= pat(int'(rd_addr));

   // Filter model: inputs 12.. produce outputs one cycle later, up to m_lim.
   always @(posedge clk) begin
      if (m_clr) begin
         m_in <= 0; m_emit <= 0; m_oen <= 1'b0;
      end else begin
         m_oen <= 1'b0;
         if (fwen) begin
            m_in <= m_in + 1;
            if (m_in >= 12 && m_emit < m_lim) begin
               m_oen  <= 1'b1;
               m_post <= fpix ^ 12'hFFF;
               m_emit <= m_emit + 1;
            end
         end
      end
   end

   assign oen  = m_oen | f_oen;
   assign post = f_oen ? f_post : m_post;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int hold_at; int hold_len; int emit; bit mid_start;
      int exp_wr;  int exp_low;  bit exp_to;
   } vec_t;

   task automatic run_frame(input vec_t v);
      int nreads = 0, rd_err = 0, nlow = 0, aln_err = 0, idle = 0;
      int to_early = 0, wcnt = 0, w_err = 0, hleft = 0;
      bit held = 0, mid_done = 0, got_done = 0, prev_en = 0, was_all;
      logic to_at_done = 1'bx, busy_at_done = 1'bx;
      int prev_addr = 0;
      @(posedge clk); #1;
      start = 1'b1; m_clr = 1'b1; m_lim = v.emit;
      @(posedge clk); #1;
      start = 1'b0; m_clr = 1'b0;
      check("start_busy", busy, 1);
      check("start_to_clr", timeout, 0);
      check("start_addr", rd_addr, 0);
      check("start_rd_en", rd_en, 1);
      for (int c = 0; c < 300 && !got_done; c++) begin
         if (hleft > 0) begin
            hold = 1'b1; hleft--;
         end else if (!held && v.hold_len > 0 && int'(rd_addr) == v.hold_at && busy) begin
            held = 1; hold = 1'b1; hleft = v.hold_len - 1;
         end else hold = 1'b0;
         if (!mid_done && v.mid_start && rd_addr == 6 && busy) begin
            start = 1'b1; mid_done = 1;
         end else start = 1'b0;
         @(negedge clk);
         if (fwen !== prev_en || (prev_en && fpix !== pat(prev_addr))) aln_err++;
         was_all = (nreads == 16);
         if (rd_en) begin
            if (int'(rd_addr) != nreads) rd_err++;
            nreads++;
         end else if (busy && nreads < 16) nlow++;
         if (was_all && busy) idle = oen ? 0 : idle + 1;
         if (busy && timeout) to_early++;
         if (wen) begin
            if (int'(waddr) != wcnt || wdata !== (pat(12 + wcnt) ^ 12'hFFF)) w_err++;
            wcnt++;
         end
         if (done) begin
            got_done = 1; to_at_done = timeout; busy_at_done = busy;
         end
         prev_en = rd_en; prev_addr = int'(rd_addr);
         @(posedge clk); #1;
      end
      start = 1'b0; hold = 1'b0;
      check("done_seen", got_done, 1);
      check("reads", nreads, 16);
      check("rd_order", rd_err, 0);
      check("rd_low", nlow, v.exp_low);
      check("fwen_align", aln_err, 0);
      check("writes", wcnt, v.exp_wr);
      check("wr_data", w_err, 0);
      check("to_at_done", to_at_done, v.exp_to);
      check("busy_at_done", busy_at_done, 0);
      check("to_early", to_early, 0);
      if (v.exp_to) check("idle_cycles", idle, DMAX);
      check("post_busy", busy, 0);
      check("post_done", done, 0);
      check("to_sticky", timeout, v.exp_to);
   endtask

   initial begin
      vec_t vt[4];
      int c, dc, wc;
      vt[0] = '{0, 0, 4, 1'b0, 4, 0, 1'b0};
      vt[1] = '{5, 3, 4, 1'b0, 4, 3, 1'b0};
      vt[2] = '{0, 0, 3, 1'b0, 3, 0, 1'b1};
      vt[3] = '{0, 0, 4, 1'b1, 4, 0, 1'b0};

      rst_n = 1'b0; start = 1'b0; hold = 1'b0;
      m_clr = 1'b1; m_lim = 4; f_oen = 1'b0; f_post = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rd_en", rd_en, 0);
      check("rst_wr_en", wen, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_to", timeout, 0);
      check("rst_fwen", fwen, 0);
      check("rst_addr", rd_addr, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; m_clr = 1'b0;

      // abort a frame with reset at rd_addr 7
      start = 1'b1; m_clr = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; m_clr = 1'b0;
      c = 0;
      while (rd_addr != 7 && c < 50) begin
         @(posedge clk); #1; c++;
      end
      check("mid_rst_reach", rd_addr, 7);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_rd_en", rd_en, 0);
      check("mid_rst_wr_en", wen, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_addr", rd_addr, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dc = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) dc++;
      end
      check("mid_rst_no_done", dc, 0);

      // filter output while idle must not write
      @(posedge clk); #1;
      f_oen = 1'b1; f_post = 12'h123;
      wc = 0;
      repeat (3) begin
         @(negedge clk);
         if (wen) wc++;
         @(posedge clk); #1;
      end
      f_oen = 1'b0;
      @(negedge clk);
      if (wen) wc++;
      check("idle_oen_wen", wc, 0);

      for (int i = 0; i < 4; i++) run_frame(vt[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
